// File: rtl/peripheral_noc_vchannel_demux_buffer.sv
// Receive side of a virtual-channel link: demultiplexes the shared flit bus
// into one FIFO per channel and presents independent per-channel streams.
module peripheral_noc_vchannel_demux_buffer #(
    parameter int FLIT_WIDTH = 32,
    parameter int CHANNELS   = 7,
    parameter int DEPTH      = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [FLIT_WIDTH-1:0]          in_flit,
    input  logic                           in_last,
    input  logic [CHANNELS-1:0]            in_valid,
    output logic [CHANNELS-1:0]            in_ready,
    output logic [CHANNELS*FLIT_WIDTH-1:0] out_flit,
    output logic [CHANNELS-1:0]            out_last,
    output logic [CHANNELS-1:0]            out_valid,
    input  logic [CHANNELS-1:0]            out_ready,
    output logic                           protocol_error
);

    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = FLIT_WIDTH + 1;

    logic multi_hot;
    logic overflow;
    logic illegal;
    logic protocol_error_reg;

    // x & (x-1) clears the lowest set bit; anything left means more than one bit was set.
    assign multi_hot = |(in_valid & (in_valid - CHANNELS'(1)));
    assign overflow  = |(in_valid & ~in_ready);
    assign illegal   = multi_hot | overflow;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            protocol_error_reg <= 1'b0;
        end else begin
            protocol_error_reg <= illegal;
        end
    end

    assign protocol_error = protocol_error_reg;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic [ENTRY_W-1:0] mem_reg [DEPTH];
            logic [PTR_W-1:0]   wr_ptr_reg;
            logic [PTR_W-1:0]   wr_ptr_next;
            logic [PTR_W-1:0]   rd_ptr_reg;
            logic [PTR_W-1:0]   rd_ptr_next;
            logic [CNT_W-1:0]   count_reg;
            logic [CNT_W-1:0]   count_next;
            logic               wr_en;
            logic               rd_en;

            // Any illegal input suppresses every write that cycle, including this channel's.
            assign wr_en = in_valid[gi] & in_ready[gi] & ~illegal;
            assign rd_en = out_valid[gi] & out_ready[gi];

            assign in_ready[gi]  = (count_reg != CNT_W'(DEPTH));
            assign out_valid[gi] = (count_reg != '0);
            assign {out_last[gi], out_flit[gi*FLIT_WIDTH +: FLIT_WIDTH]} = mem_reg[rd_ptr_reg];

            always_comb begin
                wr_ptr_next = wr_ptr_reg;
                rd_ptr_next = rd_ptr_reg;
                count_next  = count_reg;
                if (wr_en) begin
                    wr_ptr_next = (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
                end
                if (rd_en) begin
                    rd_ptr_next = (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
                end
                case ({wr_en, rd_en})
                    2'b10:   count_next = count_reg + CNT_W'(1);
                    2'b01:   count_next = count_reg - CNT_W'(1);
                    default: count_next = count_reg;
                endcase
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                    for (int i = 0; i < DEPTH; i++) begin
                        mem_reg[i] <= '0;
                    end
                end else begin
                    wr_ptr_reg <= wr_ptr_next;
                    rd_ptr_reg <= rd_ptr_next;
                    count_reg  <= count_next;
                    if (wr_en) begin
                        mem_reg[wr_ptr_reg] <= {in_last, in_flit};
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_peripheral_noc_vchannel_demux_buffer.sv
// Bench for the virtual-channel demux buffer: directed and random traffic
// compared each cycle against per-channel queues of expected flits.
module tb_peripheral_noc_vchannel_demux_buffer;

    localparam int FW    = 32;
    localparam int CH    = 7;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [FW-1:0]     in_flit;
    logic              in_last;
    logic [CH-1:0]     in_valid;
    logic [CH-1:0]     in_ready;
    logic [CH*FW-1:0]  out_flit;
    logic [CH-1:0]     out_last;
    logic [CH-1:0]     out_valid;
    logic [CH-1:0]     out_ready;
    logic              protocol_error;

    int total_cnt = 0;
    int bad_cnt   = 0;
    int cyc_cnt   = 0;

    // Expected contents per channel, head at index 0: {last, flit}.
    logic [FW:0] mq [CH][$];
    logic        exp_perr;

    peripheral_noc_vchannel_demux_buffer #(
        .FLIT_WIDTH (FW),
        .CHANNELS   (CH),
        .DEPTH      (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_flit        (in_flit),
        .in_last        (in_last),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out_flit       (out_flit),
        .out_last       (out_last),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .protocol_error (protocol_error)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic compare_all();
        logic [FW:0] e;
        for (int c = 0; c < CH; c++) begin
            check_eq($sformatf("in_ready[%0d]", c), 64'(in_ready[c]), 64'(mq[c].size() != DEPTH));
            check_eq($sformatf("out_valid[%0d]", c), 64'(out_valid[c]), 64'(mq[c].size() != 0));
            if (mq[c].size() > 0) begin
                e = mq[c][0];
                check_eq($sformatf("out_flit[%0d]", c), 64'(out_flit[c*FW +: FW]), 64'(e[FW-1:0]));
                check_eq($sformatf("out_last[%0d]", c), 64'(out_last[c]), 64'(e[FW]));
            end
        end
        check_eq("protocol_error", 64'(protocol_error), 64'(exp_perr));
    endtask

    // One clock: check outputs at the falling edge, drive new inputs, advance the model.
    task automatic cycle(input logic [CH-1:0] v, input logic [FW-1:0] f, input logic l,
                         input logic [CH-1:0] ordy);
        logic bad;
        @(negedge clk);
        compare_all();
        in_valid  = v;
        in_flit   = f;
        in_last   = l;
        out_ready = ordy;
        cyc_cnt++;
        $display("cyc=%0d valid=%b flit=%h last=%b out_ready=%b", cyc_cnt, v, f, l, ordy);
        bad = ($countones(v) > 1);
        for (int c = 0; c < CH; c++) begin
            if (v[c] && mq[c].size() == DEPTH) bad = 1'b1;
        end
        for (int c = 0; c < CH; c++) begin
            if (ordy[c] && mq[c].size() > 0) void'(mq[c].pop_front());
        end
        if (!bad) begin
            for (int c = 0; c < CH; c++) begin
                if (v[c]) mq[c].push_back({l, f});
            end
        end
        exp_perr = bad;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        check_eq({tag, "_in_ready"}, 64'(in_ready), 64'(7'h7F));
        check_eq({tag, "_perr"}, 64'(protocol_error), 64'(0));
        for (int c = 0; c < CH; c++) begin
            check_eq($sformatf("%s_out_flit[%0d]", tag, c), 64'(out_flit[c*FW +: FW]), 64'(0));
        end
        check_eq({tag, "_out_last"}, 64'(out_last), 64'(0));
    endtask

    initial begin
        logic [CH-1:0] v;
        int            a;
        int            b;
        rst       = 1'b0;
        in_valid  = '0;
        in_flit   = '0;
        in_last   = 1'b0;
        out_ready = '0;
        exp_perr  = 1'b0;

        #22;
        check_reset_outputs("reset");
        rst = 1'b1;

        // Fill channel 2, last flag on the fourth flit only.
        for (int i = 0; i < 4; i++) cycle(7'b0000100, 32'hA0 + 32'(i), (i == 3), '0);
        // Full channel: read happens, write is rejected and flagged.
        cycle(7'b0000100, 32'hEE, 1'b0, 7'b0000100);
        for (int i = 0; i < 4; i++) cycle('0, '0, 1'b0, 7'b0000100);

        // Interleave channels 0 and 5 with channel 0 stalled.
        cycle(7'b0000001, 32'h10, 1'b0, 7'b0100000);
        cycle(7'b0100000, 32'h50, 1'b0, 7'b0100000);
        cycle(7'b0000001, 32'h11, 1'b1, 7'b0100000);
        cycle(7'b0100000, 32'h51, 1'b1, 7'b0100000);
        cycle('0, '0, 1'b0, 7'b0100000);
        cycle('0, '0, 1'b0, 7'b0000001);
        cycle('0, '0, 1'b0, 7'b0000001);

        // Multi-hot, then back-to-back violations.
        cycle(7'b0000101, 32'hFF, 1'b0, '0);
        cycle(7'b0000011, 32'hFE, 1'b0, '0);
        cycle('0, '0, 1'b0, '0);
        cycle('0, '0, 1'b0, '0);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            a = $urandom_range(0, 9);
            v = '0;
            if (a == 0) begin
                v = '0;
            end else if (a == 1) begin
                a = $urandom_range(0, CH - 1);
                b = (a + $urandom_range(1, CH - 1)) % CH;
                v[a] = 1'b1;
                v[b] = 1'b1;
            end else begin
                v[$urandom_range(0, CH - 1)] = 1'b1;
            end
            cycle(v, $urandom, 1'($urandom_range(0, 1)), CH'($urandom & $urandom));
        end
        for (int i = 0; i < DEPTH + 1; i++) cycle('0, '0, 1'b0, '1);

        // Async reset with channels 1 and 3 holding three flits each.
        for (int i = 0; i < 3; i++) begin
            cycle(7'b0000010, 32'h100 + 32'(i), 1'b0, '0);
            cycle(7'b0001000, 32'h300 + 32'(i), 1'b0, '0);
        end
        @(negedge clk);
        compare_all();
        in_valid = '0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        for (int c = 0; c < CH; c++) mq[c].delete();
        exp_perr = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b1;

        for (int n = 0; n < 40; n++) begin
            v = '0;
            v[$urandom_range(0, CH - 1)] = 1'b1;
            cycle(v, $urandom, 1'($urandom_range(0, 1)), CH'($urandom));
        end
        @(negedge clk);
        compare_all();

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/peripheral_noc_vchannel_demux_buffer.md
# peripheral_noc_vchannel_demux_buffer

Receive side of a virtual-channel link: accepts the shared flit/last bus with one-hot per-channel valid produced by the virtual-channel mux, demultiplexes each flit into a per-channel FIFO, and presents CHANNELS independent flit streams to the router input stage. Per-channel `in_ready` reflects FIFO space only, so it closes the loop with the upstream mux's per-channel ready gating without combinational paths back through this block.

## Interface
- FLIT_WIDTH, 32, flit payload width in bits
- CHANNELS, 7, number of virtual channels (≥1)
- DEPTH, 4, FIFO entries per channel (≥2, any integer)

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset; asynchronous, active-low (asserted when 0)
- in_flit  input  FLIT_WIDTH  shared flit bus
- in_last  input  1  last flit of packet, qualifies in_flit
- in_valid  input  CHANNELS  one-hot valid selecting the target channel; all-zero = idle
- in_ready  output  CHANNELS  per-channel FIFO not full
- out_flit  output  CHANNELS×FLIT_WIDTH  head flit per channel
- out_last  output  CHANNELS  head last flag per channel
- out_valid  output  CHANNELS  channel FIFO not empty
- out_ready  input  CHANNELS  per-channel consumer accept
- protocol_error  output  1  one-cycle pulse on illegal input

## Operation
- Per channel c: circular FIFO of DEPTH entries {flit, last}, write pointer, read pointer, occupancy count 0..DEPTH (width clog2(DEPTH+1)). Pointers wrap from DEPTH-1 to 0 (not power-of-two dependent).
- Write to c: in_valid[c] & in_ready[c] & in_valid one-hot. Stores {in_flit, in_last} at wr_ptr[c], increments wr_ptr and count.
- Read from c: out_valid[c] & out_ready[c]. Increments rd_ptr, decrements count.
- Simultaneous write and read on same channel: both occur, count unchanged.
- in_ready[c] = (count[c] != DEPTH); depends on registered state only, never on in_valid or out_ready.
- out_valid[c] = (count[c] != 0); out_flit[c]/out_last[c] = entry at rd_ptr[c]; both from registered state.
- No bypass: when full, a same-cycle read does not make in_ready high that cycle.
- Illegal input, flagged by protocol_error = 1 on the next cycle, nothing written on any channel that cycle:
  - in_valid has more than one bit set.
  - in_valid[c] = 1 with in_ready[c] = 0 (write to full channel); flit dropped.
- in_last is stored verbatim; the block does not track packet boundaries.

## Timing
- Reset asserted (rst=0), immediately and asynchronously: all counts, pointers and storage cleared to 0. out_valid=0, out_flit=0, out_last=0, in_ready=all-ones, protocol_error=0.
- Reset asserted mid-packet: all buffered flits discarded, no partial output after release.
- First edge after release may accept writes.
- Latency: flit written at edge N is visible on out_* after edge N (one cycle); combinational in->out path is forbidden.
- Throughput: one write per cycle (any channel) plus one read per channel per cycle.
- Per-channel ordering is FIFO; channels are fully independent (a stalled channel never blocks another).
- protocol_error is registered: high for exactly the cycle after the offending input; back-to-back violations give consecutive high cycles.

## Test plan
- Reset/idle: hold rst=0, then release with in_valid=0 -> out_valid=0, in_ready=7'h7F, protocol_error=0, out_flit all zero.
- Single channel fill: DEPTH=4, write 0xA0..0xA3 to channel 2 with out_ready=0 -> in_ready[2]=0 after 4th write; set out_ready[2]=1 -> reads 0xA0,0xA1,0xA2,0xA3 in order, last flag on 0xA3 only if driven so.
- Full-and-read same cycle: channel 2 full, out_ready[2]=1, in_valid[2]=1 -> read occurs, write blocked, protocol_error=1 next cycle, count becomes 3.
- Interleave: alternate writes to channel 0 (0x10,0x11) and channel 5 (0x50,0x51), out_ready[0]=0 -> channel 5 drains 0x50,0x51 while channel 0 holds both; then channel 0 drains in order.
- Multi-hot: in_valid=7'b0000101 with in_flit=0xFF -> no write on channels 0 or 2, protocol_error=1 for one cycle.
- Async reset mid-traffic: channels 1 and 3 holding 3 flits, drive rst=0 between edges -> out_valid=0 and in_ready=all-ones before next edge; no stale flit after release.
